// File: rtl/rv32_load_store_unit.sv
// RV32 data-memory access stage: launches one aligned request/acknowledge access per start,
// formats load data for write-back and reports misaligned, illegal and timed-out accesses.
module rv32_load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] data_addr_bus,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fault_code,
    output logic [31:0] data_reg_d1,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_MISALGN = 2'd1;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd3;

    function automatic logic [3:0] lane_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] s;
        case (f3)
            3'd0:    s = 4'b0001 << off;
            3'd1:    s = 4'b0011 << off;
            3'd2:    s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        case (f3)
            3'd0:    w = {4{sd[7:0]}};
            3'd1:    w = {2{sd[15:0]}};
            3'd2:    w = sd;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Words are only ever read at offset 0, so the shifted word is the word itself.
    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'd0:    r = {{24{sh[7]}}, sh[7:0]};
            3'd1:    r = {{16{sh[15]}}, sh[15:0]};
            3'd2:    r = sh;
            3'd4:    r = {24'h00_0000, sh[7:0]};
            3'd5:    r = {16'h0000, sh[15:0]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_nxt_s;
    logic [1:0]  fault_nxt_s;
    logic        launch_s;
    logic        ld_upd_s;
    logic        illegal_s;
    logic        misaligned_s;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;
    logic        busy_r;
    logic        done_r;
    logic [1:0]  fault_r;
    logic [31:0] data_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [3:0]  mem_wstrb_r;
    logic [31:0] mem_wdata_r;

    // Launch classification: funct3[1:0] encodes the access size for both loads and stores.
    always_comb begin
        illegal_s = (load && store)
                 || (load && ((funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7)))
                 || (store && (funct3 >= 3'd3));
        case (funct3[1:0])
            2'd1:    misaligned_s = data_addr_bus[0];
            2'd2:    misaligned_s = (data_addr_bus[1:0] != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
    end

    // Next-state, fault classification and timeout counting.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        fault_nxt_s = FAULT_NONE;
        launch_s    = 1'b0;
        ld_upd_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 8'd0;
                if (start && (load || store)) begin
                    launch_s = 1'b1;
                    if (illegal_s) begin
                        state_nxt_s = ST_DONE;
                        fault_nxt_s = FAULT_ILLEGAL;
                    end else if (misaligned_s) begin
                        state_nxt_s = ST_DONE;
                        fault_nxt_s = FAULT_MISALGN;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_nxt_s = ST_RESP;
                    ld_upd_s    = ~mem_we_r;
                    cnt_nxt_s   = 8'd0;
                end else if (cnt_r == TMO_LAST) begin
                    state_nxt_s = ST_DONE;
                    fault_nxt_s = FAULT_TIMEOUT;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            ST_RESP: state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, registered status outputs, latched request fields and load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            funct3_r    <= 3'd0;
            off_r       <= 2'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fault_r     <= FAULT_NONE;
            data_r      <= 32'h0000_0000;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wstrb_r <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_nxt_s == ST_DONE);
            mem_req_r <= (state_nxt_s == ST_REQ);
            fault_r   <= fault_nxt_s;
            if (launch_s) begin
                funct3_r    <= funct3;
                off_r       <= data_addr_bus[1:0];
                mem_addr_r  <= {data_addr_bus[31:2], 2'b00};
                mem_we_r    <= store && !load;
                mem_wstrb_r <= (store && !load) ? lane_strb(funct3, data_addr_bus[1:0]) : 4'b0000;
                mem_wdata_r <= (store && !load) ? lane_wdata(funct3, store_data) : 32'h0000_0000;
            end
            if (ld_upd_s) begin
                data_r <= load_format(funct3_r, off_r, mem_rdata);
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign fault_code  = fault_r;
    assign data_reg_d1 = data_r;
    assign mem_req     = mem_req_r;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wstrb   = mem_wstrb_r;
    assign mem_wdata   = mem_wdata_r;

endmodule

// File: doc/rv32_load_store_unit.md
# rv32_load_store_unit

Data-memory access stage of the RV32 core, directly downstream of the register bank. It consumes the effective address (`data_addr_bus`) and store operand (`reg_s2`) from the register bank. It runs a request/acknowledge transaction on the data-memory port with byte-lane alignment, and returns sign- or zero-extended load data on `data_reg_d1`, the register bank's write-back source 3. Misaligned accesses, illegal size codes and bus timeouts are reported as faults and never reach memory.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles `mem_req` stays high without `mem_ack` before the access is aborted (range 1..255).
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: one-cycle launch pulse from the control unit.
- `load` input 1: the launched access is a load.
- `store` input 1: the launched access is a store.
- `funct3` input 3: RV32I size/sign code, `code_bus[14:12]`.
- `data_addr_bus` input 32: effective byte address from the register bank.
- `store_data` input 32: store operand (`reg_s2`).
- `busy` output 1: access in progress.
- `done` output 1: one-cycle completion pulse, raised for success or fault.
- `fault_code` output 2: valid while `done` is high. 0 = none, 1 = misaligned, 2 = illegal (bad funct3 or load&store), 3 = bus timeout.
- `data_reg_d1` output 32: formatted load result.
- `mem_req` output 1: memory request.
- `mem_we` output 1: 1 = write.
- `mem_addr` output 32: word address, `{addr[31:2],2'b00}`.
- `mem_wstrb` output 4: byte write enables.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_rdata` input 32: read data, sampled in the `mem_ack` cycle.
- `mem_ack` input 1: memory completion; legal in the first `mem_req` cycle.

## Operation
- States: IDLE, REQ, RESP, DONE. `busy` = (state != IDLE).
- IDLE: on `start` with `load` or `store`, latch address, funct3, store data and direction.
  - Classify in the same edge:
    - both `load` and `store`, or load funct3 ∈ {3,6,7}, or store funct3 ≥ 3 → fault 2, go to DONE;
    - halfword with `addr[0]`=1, or word with `addr[1:0]`≠0 → fault 1, go to DONE;
    - otherwise go to REQ.
  - `start` with neither `load` nor `store` is ignored.
- REQ: `mem_req`=1; `mem_addr`, `mem_we`, `mem_wstrb`, `mem_wdata` held stable.
  - On `mem_ack`: go to RESP. For a load, format `mem_rdata` into `data_reg_d1` on the same edge.
  - If the timeout counter reaches `TIMEOUT_CYCLES` without `mem_ack`: drop `mem_req`, fault 3, go to DONE.
- RESP: one bubble cycle, `mem_req`=0, then go to DONE with fault 0.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` while `busy` is ignored and not queued.
- Store lanes (off = `addr[1:0]`):
  - SB: `mem_wstrb`=0001<<off, `mem_wdata`={4{sd[7:0]}}.
  - SH: `mem_wstrb`=0011<<off, `mem_wdata`={2{sd[15:0]}}.
  - SW: `mem_wstrb`=1111, `mem_wdata`=sd.
- `mem_wstrb`=0000 for loads.
- Load formatting:
  - byte = `rdata[8*off+:8]`; half = `rdata[8*off+:16]`.
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- `data_reg_d1` changes only on a successful load. It holds through stores, faults and idle.

## Timing
- Reset (rst high at an edge): state IDLE, timeout counter 0. `busy`, `done`, `fault_code`, `data_reg_d1`, `mem_req`, `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata` all 0.
- Reset mid-transaction: `mem_req` low after that edge. No `done` pulse; the access is abandoned.
- `start` sampled at edge 0 → `busy` and `mem_req` high after edge 0.
  - `mem_ack` in cycle k → RESP after edge k, `done` high after edge k+1, `busy` low after edge k+2.
  - Minimum latency, with ack in the first request cycle: `done` 2 cycles after `start`.
- Fault at launch: `done` with fault 1 or 2 is high the cycle after the `start` edge. `mem_req` never asserts.
- Timeout: `mem_req` stays high for exactly `TIMEOUT_CYCLES` cycles, then `done` with fault 3 the next cycle.
- `mem_ack` outside REQ is ignored.
- `data_reg_d1` is valid in the `done` cycle and stable until the next successful load.

## Test plan
- LW at 0x0000_0100, ack in the first cycle with rdata 0xDEADBEEF → `mem_addr`=0x100, `done` 2 cycles after `start`, `data_reg_d1`=0xDEADBEEF, `fault_code`=0.
- LB/LBU at 0x103, rdata 0x80FF_0000 → LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at 0x102 gives 0xFFFF80FF.
- SB at 0x201 with sd 0x1234_56AB → `mem_wstrb`=0010, `mem_wdata`=0xABABABAB, `mem_we`=1, `data_reg_d1` unchanged.
- SH at 0x203, then LW at 0x102 → each gives `done` the next cycle with `fault_code`=1 and no `mem_req`. `load`&`store` together, or load funct3=3 → `fault_code`=2.
- `TIMEOUT_CYCLES`=4 and `mem_ack` never asserted → `mem_req` high for 4 cycles, then `done` with `fault_code`=3. A `start` pulse during `busy` is ignored.
- `rst` asserted while in REQ → `mem_req`, `busy` and `data_reg_d1` read 0 after the edge, no `done` pulse. The next launch completes normally.
